// File: rtl/mac_multi_matcher.sv
// -----------------------------------------------------------------------------
// mac_multi_matcher
//
// Purpose:
//   Scans a word-wide byte stream for any of NUM_PAT programmable byte patterns
//   (by default 6-byte MAC addresses), at every byte alignment. It is the
//   parametrised successor to the single-address MAC comparator. Each pattern
//   slot has its own enable. Match flags are sticky, the first slot to hit is
//   reported, and the stream passes through with a fixed latency.
//
// Stream handshake:
//   This is a valid-only stream with no backpressure. A beat is transferred on
//   every rising clk edge where data_valid=1. When data_valid=0, data_in is
//   ignored and all stream state (history, byte count) holds.
//
// Ports:
//   clk             in   clock; all state changes on the rising edge
//   n_rst           in   asynchronous active-low reset
//   clear           in   synchronous flush of history, count, match state and
//                        passthrough (pattern slots are kept)
//   cfg_we          in   write pattern slot cfg_idx
//   cfg_idx         in   [IDX_W]        slot to write
//   cfg_pattern     in   [8*PAT_BYTES]  pattern; the MSB byte is the first stream byte
//   cfg_en          in   enable bit stored with the slot
//   data_valid      in   data_in carries a valid word
//   data_in         in   [DATA_W]       stream word; the MSB byte is the earliest byte
//   data_out        out  [DATA_W]       data_in delayed PIPE_STAGES cycles
//   data_out_valid  out  data_valid delayed PIPE_STAGES cycles
//   match_vec       out  [NUM_PAT]      sticky per-slot match flags
//   match           out  OR of match_vec
//   match_pulse     out  one-cycle pulse when match_vec gains a bit
//   match_first_idx out  [IDX_W]        slot that matched first; held until clear
// -----------------------------------------------------------------------------
module mac_multi_matcher #(
  parameter int DATA_W      = 32,
  parameter int PAT_BYTES   = 6,
  parameter int NUM_PAT     = 4,
  parameter int PIPE_STAGES = 3,
  localparam int IDX_W      = (NUM_PAT > 1) ? $clog2(NUM_PAT) : 1
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic                   clear,
  input  logic                   cfg_we,
  input  logic [IDX_W-1:0]       cfg_idx,
  input  logic [8*PAT_BYTES-1:0] cfg_pattern,
  input  logic                   cfg_en,
  input  logic                   data_valid,
  input  logic [DATA_W-1:0]      data_in,
  output logic [DATA_W-1:0]      data_out,
  output logic                   data_out_valid,
  output logic [NUM_PAT-1:0]     match_vec,
  output logic                   match,
  output logic                   match_pulse,
  output logic [IDX_W-1:0]       match_first_idx
);

  localparam int BPW        = DATA_W / 8;
  localparam int PAT_W      = 8 * PAT_BYTES;
  localparam int HIST_BYTES = PAT_BYTES + BPW - 1;
  localparam int HIST_W     = 8 * HIST_BYTES;
  localparam int CNT_W      = $clog2(PAT_BYTES + BPW + 1);

  // Pattern slots
  logic [PAT_W-1:0]   pat_q [NUM_PAT];
  logic [NUM_PAT-1:0] en_q;

  // Stream history and fill count
  logic [HIST_W-1:0] hist_q;
  logic [HIST_W-1:0] hist_shift;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;

  // Match state
  logic [NUM_PAT-1:0] hit;
  logic [NUM_PAT-1:0] new_bits;
  logic [NUM_PAT-1:0] match_vec_q;
  logic               match_pulse_q;
  logic [IDX_W-1:0]   first_idx_q;
  logic [IDX_W-1:0]   first_sel;

  // Passthrough pipeline
  logic [DATA_W-1:0]      pipe_data [PIPE_STAGES];
  logic [PIPE_STAGES-1:0] pipe_valid;

  // History after accepting the current word: the oldest BPW bytes fall off
  // the top and data_in becomes the newest BPW bytes. Every comparison window
  // that ends inside the current word lies wholly within this value.
  generate
    if (HIST_BYTES > BPW) begin : g_hist_shift
      assign hist_shift = {hist_q[HIST_W-DATA_W-1:0], data_in};
    end else begin : g_hist_word
      assign hist_shift = data_in;
    end
  endgenerate

  // The oldest word of the history is only ever shifted out. No window
  // reaches back that far.
  logic unused_hist_top;
  assign unused_hist_top = ^hist_q[HIST_W-1 -: DATA_W];

  // Saturating fill count. It only has to tell whether enough real bytes
  // have arrived to fill a window.
  always_comb begin
    cnt_d = cnt_q;
    if (int'(cnt_q) + BPW >= PAT_BYTES) cnt_d = CNT_W'(PAT_BYTES);
    else                                cnt_d = cnt_q + CNT_W'(BPW);
  end

  // Window ending at byte j of data_in (j=0 is the earliest byte). Its
  // newest byte sits at byte offset BPW-1-j from the LSB of hist_shift.
  // A window qualifies only once it holds no reset-zero filler bytes.
  always_comb begin
    hit = '0;
    for (int i = 0; i < NUM_PAT; i++) begin
      for (int j = 0; j < BPW; j++) begin
        if (data_valid && en_q[i] &&
            (int'(cnt_q) + j + 1 >= PAT_BYTES) &&
            (hist_shift[8*(BPW-1-j) + PAT_W - 1 -: PAT_W] == pat_q[i])) begin
          hit[i] = 1'b1;
        end
      end
    end
  end

  assign new_bits = hit & ~match_vec_q;

  // The lowest-index newly hit slot wins. The loop runs downward so that
  // the last assignment comes from the lowest index.
  always_comb begin
    first_sel = '0;
    for (int i = NUM_PAT - 1; i >= 0; i--) begin
      if (new_bits[i]) first_sel = IDX_W'(i);
    end
  end

  // Pattern slots. clear leaves them alone. A write takes effect from the
  // next cycle, so a beat on the same cycle is compared with the old slot.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < NUM_PAT; i++) pat_q[i] <= '0;
      en_q <= '0;
    end else if (cfg_we && (int'(cfg_idx) < NUM_PAT)) begin
      pat_q[cfg_idx] <= cfg_pattern;
      en_q[cfg_idx]  <= cfg_en;
    end
  end

  // History, count and match state. clear takes priority over a beat on
  // the same cycle, so that beat is dropped.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      hist_q        <= '0;
      cnt_q         <= '0;
      match_vec_q   <= '0;
      match_pulse_q <= 1'b0;
      first_idx_q   <= '0;
    end else if (clear) begin
      hist_q        <= '0;
      cnt_q         <= '0;
      match_vec_q   <= '0;
      match_pulse_q <= 1'b0;
      first_idx_q   <= '0;
    end else begin
      if (data_valid) begin
        hist_q <= hist_shift;
        cnt_q  <= cnt_d;
      end
      match_vec_q   <= match_vec_q | hit;
      match_pulse_q <= |new_bits;
      if ((match_vec_q == '0) && (|new_bits)) first_idx_q <= first_sel;
    end
  end

  // Fixed-latency passthrough. It advances every cycle, whether or not the
  // input is valid.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int s = 0; s < PIPE_STAGES; s++) pipe_data[s] <= '0;
      pipe_valid <= '0;
    end else if (clear) begin
      for (int s = 0; s < PIPE_STAGES; s++) pipe_data[s] <= '0;
      pipe_valid <= '0;
    end else begin
      pipe_data[0]  <= data_in;
      pipe_valid[0] <= data_valid;
      for (int s = 1; s < PIPE_STAGES; s++) begin
        pipe_data[s]  <= pipe_data[s-1];
        pipe_valid[s] <= pipe_valid[s-1];
      end
    end
  end

  assign data_out        = pipe_data[PIPE_STAGES-1];
  assign data_out_valid  = pipe_valid[PIPE_STAGES-1];
  assign match_vec       = match_vec_q;
  assign match           = |match_vec_q;
  assign match_pulse     = match_pulse_q;
  assign match_first_idx = first_idx_q;

endmodule

// File: tb/tb_mac_multi_matcher.sv
// -----------------------------------------------------------------------------
// tb_mac_multi_matcher
//
// Table-driven bench for mac_multi_matcher at default parameters. Each table
// row gives the inputs for one clock cycle, together with the match outputs
// expected just after that cycle's rising edge. The passthrough outputs are
// checked on every row against a small delay-line model. Hand-written
// sequences cover the reset state and an asynchronous reset taken mid-run.
// -----------------------------------------------------------------------------
module tb_mac_multi_matcher;

  localparam int DATA_W = 32;
  localparam int PAT_BYTES = 6;
  localparam int NUM_PAT = 4;
  localparam int PIPE_STAGES = 3;
  localparam int IDX_W = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  logic                   clear = 1'b0;
  logic                   cfg_we = 1'b0;
  logic [IDX_W-1:0]       cfg_idx = '0;
  logic [8*PAT_BYTES-1:0] cfg_pattern = '0;
  logic                   cfg_en = 1'b0;
  logic                   data_valid = 1'b0;
  logic [DATA_W-1:0]      data_in = '0;
  logic [DATA_W-1:0]      data_out;
  logic                   data_out_valid;
  logic [NUM_PAT-1:0]     match_vec;
  logic                   match;
  logic                   match_pulse;
  logic [IDX_W-1:0]       match_first_idx;

  mac_multi_matcher #(
    .DATA_W(DATA_W), .PAT_BYTES(PAT_BYTES), .NUM_PAT(NUM_PAT), .PIPE_STAGES(PIPE_STAGES)
  ) dut (
    .clk(clk), .n_rst(n_rst), .clear(clear),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_pattern(cfg_pattern), .cfg_en(cfg_en),
    .data_valid(data_valid), .data_in(data_in),
    .data_out(data_out), .data_out_valid(data_out_valid),
    .match_vec(match_vec), .match(match), .match_pulse(match_pulse),
    .match_first_idx(match_first_idx)
  );

  // ---------------- vector table ----------------
  typedef struct {
    logic        we;
    logic [1:0]  idx;
    logic [47:0] pat;
    logic        en;
    logic        clr;
    logic        dv;
    logic [31:0] din;
    logic [3:0]  ev;   // expected match_vec
    logic        ep;   // expected match_pulse
    logic [1:0]  ei;   // expected match_first_idx
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic we, logic [1:0] idx, logic [47:0] pat, logic en,
                              logic clr, logic dv, logic [31:0] din,
                              logic [3:0] ev, logic ep, logic [1:0] ei);
    vec_t v;
    v.we = we; v.idx = idx; v.pat = pat; v.en = en; v.clr = clr;
    v.dv = dv; v.din = din; v.ev = ev; v.ep = ep; v.ei = ei;
    return v;
  endfunction

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  int cur_row = -1;

  // Passthrough model: exp_q[0] is the newest stage.
  logic [DATA_W-1:0] exp_q[$];
  logic              exp_v[$];

  task automatic model_reset();
    exp_q = {};
    exp_v = {};
    for (int s = 0; s < PIPE_STAGES; s++) begin
      exp_q.push_back('0);
      exp_v.push_back(1'b0);
    end
  endtask

  task automatic model_step(logic clr, logic dv, logic [DATA_W-1:0] din);
    if (clr) begin
      model_reset();
    end else begin
      exp_q.push_front(din);
      exp_v.push_front(dv);
      void'(exp_q.pop_back());
      void'(exp_v.pop_back());
    end
  endtask

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d actual %h required %h", name, cur_row, act, exp);
    end
  endtask

  task automatic chk_pass();
    chk("data_out", 64'(data_out), 64'(exp_q[PIPE_STAGES-1]));
    chk("data_out_valid", 64'(data_out_valid), 64'(exp_v[PIPE_STAGES-1]));
  endtask

  // ---------------- driver ----------------
  task automatic apply(vec_t v);
    @(negedge clk);
    cfg_we = v.we; cfg_idx = v.idx; cfg_pattern = v.pat; cfg_en = v.en;
    clear = v.clr; data_valid = v.dv; data_in = v.din;
    @(posedge clk);
    #1;
    model_step(v.clr, v.dv, v.din);
    chk("match_vec", 64'(match_vec), 64'(v.ev));
    chk("match", 64'(match), 64'(|v.ev));
    chk("match_pulse", 64'(match_pulse), 64'(v.ep));
    chk("match_first_idx", 64'(match_first_idx), 64'(v.ei));
    chk_pass();
  endtask

  localparam logic [47:0] MAC_A = 48'h0A1B2C3D4E5F;
  localparam logic [47:0] MAC_B = 48'hAABBCCDDEEFF;
  localparam logic [47:0] MAC_C = 48'h112233445566;
  localparam logic [47:0] MAC_D = 48'h665544332211;

  initial begin
    // ---- basic match ----
    vecs.push_back(mk(1, 0, MAC_A, 1, 0, 0, 32'h0,        4'b0000, 0, 0));
    vecs.push_back(mk(0, 0, 48'h0, 0, 0, 1, 32'h0A1B2C3D, 4'b0000, 0, 0));
    vecs.push_back(mk(0, 0, 48'h0, 0, 0, 1, 32'h4E5F0000, 4'b0001, 1, 0));
    vecs.push_back(mk(0, 0, 48'h0, 0, 0, 0, 32'h0,        4'b0001, 0, 0));
    vecs.push_back(mk(0, 0, 48'h0, 0, 1, 0, 32'h0,        4'b0000, 0, 0));
    // ---- alignment: match spans three words with an idle gap ----
    vecs.push_back(mk(0, 0, 48'h0, 0, 0, 1, 32'h1122330A, 4'b0000, 0, 0));
    vecs.push_back(mk(0, 0, 48'h0, 0, 0, 0, 32'hDEADBEEF, 4'b0000, 0, 0));
    vecs.push_back(mk(0, 0, 48'h0, 0, 0, 0, 32'h0,        4'b0000, 0, 0));
    vecs.push_back(mk(0, 0, 48'h0, 0, 0, 1, 32'h1B2C3D4E, 4'b0000, 0, 0));
    vecs.push_back(mk(0, 0, 48'h0, 0, 0, 1, 32'h5F667788, 4'b0001, 1, 0));
    vecs.push_back(mk(0, 0, 48'h0, 0, 0, 1, 32'h0A1B2C3D, 4'b0001, 0, 0));
    vecs.push_back(mk(0, 0, 48'h0, 0, 0, 1, 32'h4E5F0000, 4'b0001, 0, 0));
    vecs.push_back(mk(0, 0, 48'h0, 0, 1, 0, 32'h0,        4'b0000, 0, 0));
    // ---- fill guard: an all-zero pattern needs six real bytes ----
    vecs.push_back(mk(1, 0, 48'h0, 1, 0, 0, 32'h0,        4'b0000, 0, 0));
    vecs.push_back(mk(0, 0, 48'h0, 0, 0, 1, 32'h0,        4'b0000, 0, 0));
    vecs.push_back(mk(0, 0, 48'h0, 0, 0, 1, 32'h0,        4'b0001, 1, 0));
    vecs.push_back(mk(0, 0, 48'h0, 0, 1, 0, 32'h0,        4'b0000, 0, 0));
    // ---- priority: two slots hit together, a third later ----
    vecs.push_back(mk(1, 1, MAC_B, 1, 0, 0, 32'h0,        4'b0000, 0, 0));
    vecs.push_back(mk(1, 2, MAC_B, 1, 0, 0, 32'h0,        4'b0000, 0, 0));
    vecs.push_back(mk(1, 0, 48'h0, 0, 0, 0, 32'h0,        4'b0000, 0, 0));
    vecs.push_back(mk(0, 0, 48'h0, 0, 0, 1, 32'hAABBCCDD, 4'b0000, 0, 0));
    vecs.push_back(mk(0, 0, 48'h0, 0, 0, 1, 32'hEEFF0000, 4'b0110, 1, 1));
    vecs.push_back(mk(1, 3, MAC_C, 1, 0, 0, 32'h0,        4'b0110, 0, 1));
    vecs.push_back(mk(0, 0, 48'h0, 0, 0, 1, 32'h11223344, 4'b0110, 0, 1));
    vecs.push_back(mk(0, 0, 48'h0, 0, 0, 1, 32'h55660000, 4'b1110, 1, 1));
    vecs.push_back(mk(0, 0, 48'h0, 0, 0, 0, 32'h0,        4'b1110, 0, 1));
    // disabling slot1 keeps its sticky flag
    vecs.push_back(mk(1, 1, MAC_B, 0, 0, 0, 32'h0,        4'b1110, 0, 1));
    // ---- clear together with a config write: the write still lands ----
    vecs.push_back(mk(1, 0, MAC_A, 1, 1, 0, 32'h0,        4'b0000, 0, 0));
    // ---- clear mid-pattern ----
    vecs.push_back(mk(0, 0, 48'h0, 0, 0, 1, 32'h0A1B2C3D, 4'b0000, 0, 0));
    vecs.push_back(mk(0, 0, 48'h0, 0, 1, 0, 32'h0,        4'b0000, 0, 0));
    vecs.push_back(mk(0, 0, 48'h0, 0, 0, 1, 32'h4E5F0000, 4'b0000, 0, 0));
    vecs.push_back(mk(0, 0, 48'h0, 0, 0, 0, 32'h0,        4'b0000, 0, 0));
    vecs.push_back(mk(0, 0, 48'h0, 0, 0, 0, 32'h0,        4'b0000, 0, 0));
    // clear on the completing beat drops it
    vecs.push_back(mk(0, 0, 48'h0, 0, 0, 1, 32'h0A1B2C3D, 4'b0000, 0, 0));
    vecs.push_back(mk(0, 0, 48'h0, 0, 1, 1, 32'h4E5F0000, 4'b0000, 0, 0));
    vecs.push_back(mk(0, 0, 48'h0, 0, 0, 1, 32'h4E5F0000, 4'b0000, 0, 0));
    vecs.push_back(mk(0, 0, 48'h0, 0, 1, 0, 32'h0,        4'b0000, 0, 0));
    // ---- config race: a beat on the write cycle sees the old slot ----
    vecs.push_back(mk(0, 0, 48'h0, 0, 0, 1, 32'h0A1B2C3D, 4'b0000, 0, 0));
    vecs.push_back(mk(1, 0, MAC_D, 1, 0, 1, 32'h4E5F0000, 4'b0001, 1, 0));
    vecs.push_back(mk(0, 0, 48'h0, 0, 1, 0, 32'h0,        4'b0000, 0, 0));
    vecs.push_back(mk(0, 0, 48'h0, 0, 0, 1, 32'h0A1B2C3D, 4'b0000, 0, 0));
    vecs.push_back(mk(1, 0, MAC_A, 1, 0, 1, 32'h4E5F0000, 4'b0000, 0, 0));
    vecs.push_back(mk(0, 0, 48'h0, 0, 0, 1, 32'h0A1B2C3D, 4'b0000, 0, 0));
    vecs.push_back(mk(0, 0, 48'h0, 0, 0, 1, 32'h4E5F0000, 4'b0001, 1, 0));
    vecs.push_back(mk(0, 0, 48'h0, 0, 0, 0, 32'h0,        4'b0001, 0, 0));

    // ---- reset state ----
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_match_vec", 64'(match_vec), 64'h0);
    chk("rst_match", 64'(match), 64'h0);
    chk("rst_match_pulse", 64'(match_pulse), 64'h0);
    chk("rst_first_idx", 64'(match_first_idx), 64'h0);
    chk_pass();
    @(negedge clk);
    n_rst = 1'b1;

    // ---- table ----
    for (int r = 0; r < vecs.size(); r++) begin
      cur_row = r;
      apply(vecs[r]);
    end

    // ---- asynchronous reset mid-run: outputs clear without a clock edge ----
    cur_row = -2;
    @(negedge clk);
    n_rst = 1'b0;
    #2;
    model_reset();
    chk("async_match_vec", 64'(match_vec), 64'h0);
    chk("async_first_idx", 64'(match_first_idx), 64'h0);
    chk_pass();
    @(negedge clk);
    n_rst = 1'b1;

    // Pattern slots are reset too, so MAC_A no longer matches.
    cur_row = -3;
    apply(mk(0, 0, 48'h0, 0, 0, 1, 32'h0A1B2C3D, 4'b0000, 0, 0));
    apply(mk(0, 0, 48'h0, 0, 0, 1, 32'h4E5F0000, 4'b0000, 0, 0));
    apply(mk(0, 0, 48'h0, 0, 0, 0, 32'h0,        4'b0000, 0, 0));

    // ---- report ----
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
